// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and types for the NTT coefficient loader.
//   DATA_WIDTH_DEF / Q_DEF / N_DEF : default coefficient width, modulus and transform size
//   TWIDDLE                         : powers of the 4th root of unity (1479) modulo 12289
//   state_e                         : loader FSM states (LOAD, SWEEP)
//   bitrev2                         : 2-bit index bit reversal used for bit-reversed loading
package ntt_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int Q_DEF          = 12289;
  localparam int N_DEF          = 4;

  // w^0..w^3 for w = 1479, where w^2 == -1 (mod 12289)
  localparam logic [31:0] TWIDDLE [4] = '{32'd1, 32'd1479, 32'd12288, 32'd10810};

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  function automatic logic [1:0] bitrev2(input logic [1:0] k);
    return {k[0], k[1]};
  endfunction

endpackage

// File: rtl/ntt_mod_reduce.sv
// ntt_mod_reduce: single conditional-subtract reduction of an incoming coefficient.
//   value        : raw coefficient
//   reduced      : value if value < Q, value - Q if Q <= value < 2Q, else 0
//   out_of_range : high when value >= 2Q (cannot be fixed by one subtraction)
module ntt_mod_reduce
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int Q          = Q_DEF
) (
  input  logic [DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0] reduced,
  output logic                  out_of_range
);

  // Compare in a widened domain so 2Q never wraps for narrow DATA_WIDTH.
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [EW-1:0] Q1 = EW'(Q);
  localparam logic [EW-1:0] Q2 = EW'(2 * Q);

  logic [EW-1:0] value_ext;
  assign value_ext = {2'b00, value};

  always_comb begin
    reduced      = '0;
    out_of_range = 1'b0;
    if (value_ext < Q1) begin
      reduced = value;
    end else if (value_ext < Q2) begin
      reduced = value - DATA_WIDTH'(Q);
    end else begin
      out_of_range = 1'b1;
    end
  end

endmodule

// File: rtl/ntt_coeff_loader.sv
// ntt_coeff_loader: gathers 4 reduced coefficients, then sweeps the external
// combinational NTT core over output indices 0..3 and streams the results.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_data/valid/ready : upstream coefficient stream (accepted only in LOAD)
//   buf0..buf3          : coefficient slots presented to the core
//   ntt_index           : output index requested from the core (0 in LOAD)
//   core_result         : combinational core answer for (buf0..3, ntt_index)
//   out_data/valid/ready/last : downstream result stream, last marks index 3
//   range_err, err_clear: sticky out-of-range flag and its clear
//   busy                : high while sweeping (mirrors the FSM state)
// Optional build macro NTT_LOADER_BITREV_EN: beat k goes to slot bitrev2(k).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and data is held while valid is
// high and ready is low.
module ntt_coeff_loader
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int Q          = Q_DEF,
  parameter int N          = N_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] buf0,
  output logic [DATA_WIDTH-1:0] buf1,
  output logic [DATA_WIDTH-1:0] buf2,
  output logic [DATA_WIDTH-1:0] buf3,
  output logic [1:0]            ntt_index,
  input  logic [DATA_WIDTH-1:0] core_result,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  range_err,
  input  logic                  err_clear,
  output logic                  busy
);

  localparam logic [0:0] ST_LOAD  = LOAD;
  localparam logic [0:0] ST_SWEEP = SWEEP;
  localparam logic [1:0] LAST_IDX = 2'(N - 1);

  logic [0:0]            state;
  logic [1:0]            load_cnt;
  logic [1:0]            sweep_cnt;
  logic [1:0]            wr_slot;
  logic [DATA_WIDTH-1:0] reduced;
  logic                  out_of_range;
  logic                  beat;
  logic                  capture;

  ntt_mod_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q          (Q)
  ) u_reduce (
    .value        (in_data),
    .reduced      (reduced),
    .out_of_range (out_of_range)
  );

`ifdef NTT_LOADER_BITREV_EN
  assign wr_slot = bitrev2(load_cnt);
`else
  assign wr_slot = load_cnt;
`endif

  assign in_ready  = (state == ST_LOAD);
  assign busy      = (state == ST_SWEEP);
  assign ntt_index = (state == ST_SWEEP) ? sweep_cnt : 2'd0;
  assign beat      = in_valid && in_ready;
  // A new result may be captured only when the output register is free or draining.
  assign capture   = (state == ST_SWEEP) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      load_cnt  <= 2'd0;
      sweep_cnt <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
      buf2      <= '0;
      buf3      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (beat) begin
        case (wr_slot)
          2'd0:    buf0 <= reduced;
          2'd1:    buf1 <= reduced;
          2'd2:    buf2 <= reduced;
          default: buf3 <= reduced;
        endcase
        if (load_cnt == LAST_IDX) begin
          state     <= ST_SWEEP;
          load_cnt  <= 2'd0;
          sweep_cnt <= 2'd0;
        end else begin
          load_cnt <= load_cnt + 2'd1;
        end
      end

      if (capture) begin
        out_data  <= core_result;
        out_valid <= 1'b1;
        out_last  <= (sweep_cnt == LAST_IDX);
        if (sweep_cnt == LAST_IDX) begin
          state     <= ST_LOAD;
          sweep_cnt <= 2'd0;
        end else begin
          sweep_cnt <= sweep_cnt + 2'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A fresh error takes priority over a simultaneous clear.
      if (beat && out_of_range) begin
        range_err <= 1'b1;
      end else if (err_clear) begin
        range_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// tb_ntt_coeff_loader: directed vectors for ntt_coeff_loader with an
// expected-result queue drained by an independent output monitor.
module tb_ntt_coeff_loader;

  localparam int DW = 32;
  localparam int QM = 12289;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] buf0, buf1, buf2, buf3;
  logic [1:0]    ntt_index;
  logic [DW-1:0] core_result;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          range_err;
  logic          err_clear;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q[$];   // {last, data}

  ntt_coeff_loader #(.DATA_WIDTH(DW), .Q(QM), .N(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .buf0        (buf0),
    .buf1        (buf1),
    .buf2        (buf2),
    .buf3        (buf3),
    .ntt_index   (ntt_index),
    .core_result (core_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .range_err   (range_err),
    .err_clear   (err_clear),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- external core model ----------------
  // result_k = sum_j buf_j * w^((j+k) mod 4) mod Q, w = 1479
  function automatic longint unsigned tw(input int i);
    case (i % 4)
      0:       return 1;
      1:       return 1479;
      2:       return 12288;
      default: return 10810;
    endcase
  endfunction

  function automatic logic [DW-1:0] core_model(input logic [DW-1:0] b0, b1, b2, b3,
                                               input logic [1:0] k);
    longint unsigned acc;
    acc = (longint'(b0) * tw(0 + k)) % QM;
    acc = (acc + (longint'(b1) * tw(1 + k)) % QM) % QM;
    acc = (acc + (longint'(b2) * tw(2 + k)) % QM) % QM;
    acc = (acc + (longint'(b3) * tw(3 + k)) % QM) % QM;
    return DW'(acc);
  endfunction

  assign core_result = core_model(buf0, buf1, buf2, buf3, ntt_index);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] r0, r1, r2, r3);
    exp_q.push_back({1'b0, r0});
    exp_q.push_back({1'b0, r1});
    exp_q.push_back({1'b0, r2});
    exp_q.push_back({1'b1, r3});
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input logic [DW-1:0] v);
    int n;
    in_data  = v;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {{DW{1'b0}}, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] a, b, c, d);
    send_beat(a);
    send_beat(b);
    send_beat(c);
    send_beat(d);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0d expected nothing", out_data);
      end else begin
        check("out_beat", {out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] snap_data, snap_b0, snap_b1, snap_b2, snap_b3;
  logic [1:0]    snap_idx;

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {{DW{1'b0}}, out_valid}, 0);
    check("rst_in_ready",  {{DW{1'b0}}, in_ready}, 1);
    check("rst_busy",      {{DW{1'b0}}, busy}, 0);
    check("rst_range_err", {{DW{1'b0}}, range_err}, 0);
    check("rst_out_data",  {1'b0, out_data}, 0);
    check("rst_buf0",      {1'b0, buf0}, 0);
    check("rst_buf3",      {1'b0, buf3}, 0);
    check("rst_ntt_index", {{(DW-1){1'b0}}, ntt_index}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // impulse in slot 0
    push_frame(1, 1479, 12288, 10810);
    send_frame(1, 0, 0, 0);
    check("sweep_busy",     {{DW{1'b0}}, busy}, 1);
    check("sweep_in_ready", {{DW{1'b0}}, in_ready}, 0);

    // all ones sum to zero at every index
    push_frame(0, 0, 0, 0);
    send_frame(1, 1, 1, 1);

    // impulse on beat 1
`ifdef NTT_LOADER_BITREV_EN
    push_frame(12288, 10810, 1, 1479);
`else
    push_frame(1479, 12288, 10810, 1);
`endif
    send_frame(0, 1, 0, 0);

    // reduction boundaries: Q -> 0, 2Q-1 -> Q-1, Q-1 -> Q-1
    push_frame(10811, 1480, 1478, 10809);
    send_frame(12289, 24577, 12288, 0);
    check("bnd_buf0_q",     {1'b0, buf0}, 0);
    check("bnd_buf1_2q_m1", {1'b0, buf1}, 12288);
    check("bnd_buf2",       {1'b0, buf2}, 12288);
    check("bnd_range_err",  {{DW{1'b0}}, range_err}, 0);

    // Q+1 reduces to 1
    push_frame(1, 1479, 12288, 10810);
    send_frame(12290, 0, 0, 0);
    check("red_buf0",      {1'b0, buf0}, 1);
    check("red_range_err", {{DW{1'b0}}, range_err}, 0);

    // 2Q is out of range; error beats a simultaneous clear
    push_frame(0, 0, 0, 0);
    err_clear = 1'b1;
    send_beat(24578);
    err_clear = 1'b0;
    check("err_wins", {{DW{1'b0}}, range_err}, 1);
    send_beat(0);
    send_beat(0);
    send_beat(0);
    check("err_buf0",   {1'b0, buf0}, 0);
    check("err_sticky", {{DW{1'b0}}, range_err}, 1);
    @(posedge clk);
    #1;
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    check("err_cleared", {{DW{1'b0}}, range_err}, 0);

    // backpressure mid-sweep
`ifdef NTT_LOADER_BITREV_EN
    push_frame(1479, 12288, 10810, 1);
`else
    push_frame(12288, 10810, 1, 1479);
`endif
    send_frame(0, 0, 1, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_out_valid", {{DW{1'b0}}, out_valid}, 1);
    snap_data = out_data;
    snap_idx  = ntt_index;
    snap_b0   = buf0;
    snap_b1   = buf1;
    snap_b2   = buf2;
    snap_b3   = buf3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_data",  {1'b0, out_data}, {1'b0, snap_data});
      check("bp_ntt_index", {{(DW-1){1'b0}}, ntt_index}, {{(DW-1){1'b0}}, snap_idx});
      check("bp_bufs", {1'b0, buf0 ^ buf1 ^ buf2 ^ buf3}, {1'b0, snap_b0 ^ snap_b1 ^ snap_b2 ^ snap_b3});
      check("bp_buf2", {1'b0, buf2}, {1'b0, snap_b2});
    end
    out_ready = 1'b1;

    // reset while sweeping index 2: only indices 0 and 1 may appear
`ifdef NTT_LOADER_BITREV_EN
    exp_q.push_back({1'b0, 32'd12288});
    exp_q.push_back({1'b0, 32'd10810});
`else
    exp_q.push_back({1'b0, 32'd1479});
    exp_q.push_back({1'b0, 32'd12288});
`endif
    send_frame(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (ntt_index == 2'd2) break;
      @(posedge clk);
      #1;
    end
    check("rs_reached_idx2", {{(DW-1){1'b0}}, ntt_index}, 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rs_out_valid", {{DW{1'b0}}, out_valid}, 0);
    check("rs_in_ready",  {{DW{1'b0}}, in_ready}, 1);
    check("rs_busy",      {{DW{1'b0}}, busy}, 0);
    check("rs_buf0",      {1'b0, buf0}, 0);
    check("rs_buf1",      {1'b0, buf1}, 0);
    check("rs_buf2",      {1'b0, buf2}, 0);
    check("rs_buf3",      {1'b0, buf3}, 0);
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (5) @(posedge clk);
    check("queue_drained", DW'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_coeff_loader.md
NTT_COEFF_LOADER -- requirements
Module: ntt_coeff_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the coefficient width in bits.
REQ-002 Parameter Q, default 12289, is the modulus.
REQ-003 Parameter N, default 4, is the transform size; only N=4 is supported.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_data, input, DATA_WIDTH bits: incoming time-domain coefficient.
REQ-007 Ports in_valid (input, 1 bit) and in_ready (output, 1 bit): upstream handshake.
REQ-008 Ports buf0..buf3, output, DATA_WIDTH bits each: coefficient slots driven to the NTT core.
REQ-009 Port ntt_index, output, 2 bits: output index currently requested from the core.
REQ-010 Port core_result, input, DATA_WIDTH bits: combinational core result for (buf0..3, ntt_index).
REQ-011 Ports out_data (output, DATA_WIDTH bits), out_valid (output, 1 bit), out_ready (input, 1 bit), out_last (output, 1 bit): downstream stream; out_last marks index 3.
REQ-012 Port range_err, output, 1 bit: sticky out-of-range flag; port err_clear, input, 1 bit, clears it.
REQ-013 Port busy, output, 1 bit: high in SWEEP.

Function
REQ-014 The FSM shall have two states: LOAD and SWEEP.
REQ-015 In LOAD, in_ready shall be 1; each in_valid&in_ready beat writes the reduced coefficient to slot load_cnt, and load_cnt increments.
REQ-016 Reduction: in_data<Q stored as-is; Q<=in_data<2Q stored as in_data-Q; in_data>=2Q stores 0 and sets range_err the next cycle.
REQ-017 On the 4th accepted beat, the FSM shall enter SWEEP with sweep_cnt=0 and load_cnt=0.
REQ-018 In SWEEP, in_ready shall be 0, buf0..3 shall be held stable, and ntt_index shall equal sweep_cnt.
REQ-019 In SWEEP, when (!out_valid || out_ready), core_result shall be registered into out_data, out_valid set to 1, out_last set to (sweep_cnt==3), and sweep_cnt incremented.
REQ-020 After capturing index 3, the FSM shall return to LOAD the next cycle; the pending output may still be outstanding while the next frame loads.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_last, and sweep_cnt shall hold.
REQ-022 When out_ready=1 and no capture occurs in that cycle, out_valid shall clear.
REQ-023 Latency: each result appears on out_data one cycle after its ntt_index is presented, absent backpressure; a frame takes 4 load cycles plus 4 sweep cycles.
REQ-024 err_clear and a new error in the same cycle: the error wins, and range_err stays 1.
REQ-025 In LOAD, ntt_index shall be 0.

Reset
REQ-026 On reset, the FSM shall go to LOAD, and load_cnt, sweep_cnt, buf0..3, out_data, out_valid, out_last, range_err, and busy shall all be 0.
REQ-027 Reset during SWEEP shall discard the frame and any pending output.

Configuration
REQ-028 With NTT_LOADER_BITREV_EN defined, beat k shall be written to slot bitrev2(k), giving slot order 0,2,1,3.
REQ-029 Without NTT_LOADER_BITREV_EN, beat k shall be written to slot k.

Structure
REQ-030 Package ntt_pkg shall hold Q, N, DATA_WIDTH defaults, twiddle constants, and the state enum (LOAD, SWEEP).
REQ-031 Sub-module ntt_mod_reduce shall perform the conditional-subtract reduction and range check.

Verification
REQ-032 Load 1,0,0,0 with out_ready=1 -> out_data sequence 1,1479,12288,10810, with out_last on the 4th.
REQ-033 Load 1,1,1,1 -> four outputs of 0.
REQ-034 Load 0,1,0,0 -> 1479,12288,10810,1 without the macro; 12288,10810,1,1479 with NTT_LOADER_BITREV_EN.
REQ-035 Load 12290,0,0,0 -> buf0=1 and range_err=0; load 24578 -> buf0=0 and range_err=1; pulse err_clear -> range_err=0.
REQ-036 Hold out_ready=0 for 5 cycles mid-sweep -> out_data, ntt_index, and buf0..3 stable; no result lost or duplicated.
REQ-037 Assert reset at sweep index 2 -> next cycle out_valid=0, in_ready=1, buf0..3=0.
